collision_score_unit: RTL

Parametrised successor to the single-monster collision/score block. It sits between the VGA drawing-request muxes and the game controller. It detects pacman/wall, monster/wall, coin and monster/pacman overlaps for N monsters, and issues frame-rate one-shot event pulses. It also aims and rate-limits the hammer wall-break command, and keeps an N-digit saturating BCD score that can add coin and bonus points in the same cycle.

---
 rtl/collision_score_unit.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/collision_score_unit.sv
// collision_score_unit
//   Overlap detection between pacman, walls, coins and N monsters, with
//   one-shot event pulses (at most one per frame), hammer wall-break aiming
//   and rate limiting, and an N-digit saturating BCD score.
// Ports:
//   clk, resetN                   clock, async active-low reset
//   startOfFrame                  one-cycle frame-start pulse
//   drawing_request_*             per-pixel drawing requests from the VGA muxes
//   pacman_wall_collision_allert  pacman wall-probe pixel
//   breakWall_req                 hammer key level
//   pacmanTopLeftX/Y, pacmanFaceDirection  pacman pose (dir: 00 dn,01 rt,10 lt,11 up)
//   upScore, playGame             bonus event (+10), coin-scoring enable
//   pacmanCollision, monsterWallCollision   combinational overlaps
//   coinCollisionPulse, monsterPacmanPulse, monsterHitMask  per-frame events
//   breakWall_pulse_command, destroyWallPixelX/Y            hammer command + aim
//   score_digits, score_saturated                           BCD score

// One BCD digit of a ripple adder.
module bcd_digit_add (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);
   logic [4:0] raw;
   logic [4:0] adj;
   assign raw = {1'b0, a} + {1'b0, b} + {4'b0, ci};
   assign adj = raw - 5'd10;
   assign co  = (raw > 5'd9);
   assign s   = co ? adj[3:0] : raw[3:0];
endmodule

module collision_score_unit #(
   parameter int N_MONSTERS             = 3,
   parameter int N_DIGITS               = 3,
   parameter int REACH                  = 16,
   parameter int PACMAN_W               = 32,
   parameter int PACMAN_H               = 32,
   parameter int HAMMER_COOLDOWN_FRAMES = 4
) (
   input  logic                    clk,
   input  logic                    resetN,
   input  logic                    startOfFrame,
   input  logic                    drawing_request_Pacman,
   input  logic                    drawing_request_Walls,
   input  logic                    pacman_wall_collision_allert,
   input  logic                    drawing_request_Coins,
   input  logic [N_MONSTERS-1:0]   drawing_request_Monsters,
   input  logic                    breakWall_req,
   input  logic [10:0]             pacmanTopLeftX,
   input  logic [10:0]             pacmanTopLeftY,
   input  logic [1:0]              pacmanFaceDirection,
   input  logic                    upScore,
   input  logic                    playGame,
   output logic                    pacmanCollision,
   output logic [N_MONSTERS-1:0]   monsterWallCollision,
   output logic                    coinCollisionPulse,
   output logic                    monsterPacmanPulse,
   output logic [N_MONSTERS-1:0]   monsterHitMask,
   output logic                    breakWall_pulse_command,
   output logic [10:0]             destroyWallPixelX,
   output logic [10:0]             destroyWallPixelY,
   output logic [4*N_DIGITS-1:0]   score_digits,
   output logic                    score_saturated
);
   localparam int CW = (HAMMER_COOLDOWN_FRAMES > 0) ? $clog2(HAMMER_COOLDOWN_FRAMES + 1) : 1;
   localparam logic [CW-1:0] COOL_LOAD = CW'(HAMMER_COOLDOWN_FRAMES);
   localparam logic [10:0]   R  = 11'(REACH);
   localparam logic [10:0]   PW = 11'(PACMAN_W);
   localparam logic [10:0]   PH = 11'(PACMAN_H);

   // ---------------- combinational overlaps ----------------
   assign pacmanCollision      = pacman_wall_collision_allert & drawing_request_Walls;
   assign monsterWallCollision = drawing_request_Monsters & {N_MONSTERS{drawing_request_Walls}};

   // ---------------- per-frame one-shots ----------------
   logic                  coin_flag, mon_flag;
   logic                  coin_fire, mon_fire;
   logic [N_MONSTERS-1:0] mon_hit;

   assign mon_hit = drawing_request_Monsters & {N_MONSTERS{drawing_request_Pacman}};
   // A hit coincident with startOfFrame belongs to the new frame, so the
   // stale flag is ignored in that cycle.
   assign coin_fire = drawing_request_Pacman & drawing_request_Coins & (~coin_flag | startOfFrame);
   assign mon_fire  = (|mon_hit) & (~mon_flag | startOfFrame);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         coin_flag          <= 1'b0;
         mon_flag           <= 1'b0;
         coinCollisionPulse <= 1'b0;
         monsterPacmanPulse <= 1'b0;
         monsterHitMask     <= '0;
      end else begin
         if (coin_fire)         coin_flag <= 1'b1;
         else if (startOfFrame) coin_flag <= 1'b0;
         if (mon_fire)          mon_flag  <= 1'b1;
         else if (startOfFrame) mon_flag  <= 1'b0;
         coinCollisionPulse <= coin_fire;
         monsterPacmanPulse <= mon_fire;
         if (mon_fire) monsterHitMask <= mon_hit;
      end
   end

   // ---------------- hammer ----------------
   logic          armed;
   logic [CW-1:0] cooldown;
   logic          brk_fire;

   // armed forces a key release between breaks; cooldown spaces them by frames.
   assign brk_fire = breakWall_req & armed & (cooldown == '0);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         armed                   <= 1'b1;
         cooldown                <= '0;
         breakWall_pulse_command <= 1'b0;
      end else begin
         breakWall_pulse_command <= brk_fire;
         if (brk_fire) begin
            armed    <= 1'b0;
            cooldown <= COOL_LOAD;
         end else begin
            if (!breakWall_req) armed <= 1'b1;
            if (startOfFrame && cooldown != '0) cooldown <= cooldown - 1'b1;
         end
      end
   end

   // ---------------- aim point (mod 2^11) ----------------
   logic [10:0] aim_x, aim_y;

   always_comb begin
      aim_x = pacmanTopLeftX + R;
      aim_y = pacmanTopLeftY + R;
      case (pacmanFaceDirection)
         2'b00: aim_y = pacmanTopLeftY + PH + R;
         2'b01: aim_x = pacmanTopLeftX + PW + R;
         2'b10: aim_x = pacmanTopLeftX - R;
         2'b11: aim_y = pacmanTopLeftY - R;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         destroyWallPixelX <= '0;
         destroyWallPixelY <= '0;
      end else begin
         destroyWallPixelX <= aim_x;
         destroyWallPixelY <= aim_y;
      end
   end

   // ---------------- BCD score ----------------
   logic [N_DIGITS-1:0][3:0] score_q, sum, addend;
   logic [N_DIGITS:0]        carry;

   // Coin adds to digit 0, bonus adds to digit 1; both in one ripple add.
   always_comb begin
      addend    = '0;
      addend[0] = {3'b0, coinCollisionPulse & playGame};
      addend[1] = {3'b0, upScore};
   end

   assign carry[0] = 1'b0;

   for (genvar i = 0; i < N_DIGITS; i++) begin : g_dig
      bcd_digit_add u_dig (
         .a  (score_q[i]),
         .b  (addend[i]),
         .ci (carry[i]),
         .s  (sum[i]),
         .co (carry[i+1])
      );
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)                score_q <= '0;
      else if (carry[N_DIGITS])   score_q <= {N_DIGITS{4'd9}};
      else                        score_q <= sum;
   end

   always_comb begin
      score_saturated = 1'b1;
      for (int i = 0; i < N_DIGITS; i++)
         if (score_q[i] != 4'd9) score_saturated = 1'b0;
   end

   assign score_digits = score_q;
endmodule
